// File: rtl/read_queue_pkg.sv
// Shared definitions for the read_queue narrow-to-wide packer.
// Contents:
//   IN_WIDTH_DEF / OUT_WIDTH_DEF : default beat and word widths.
//   state_t                      : packer state, COLLECT (gathering beats)
//                                  or HOLD (word presented downstream).
//   beats_per_word()             : number of narrow beats per wide word.
package read_queue_pkg;

   localparam int IN_WIDTH_DEF  = 32;
   localparam int OUT_WIDTH_DEF = 512;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   function automatic int beats_per_word(input int out_width, input int in_width);
      return out_width / in_width;
   endfunction

endpackage

// File: rtl/read_queue_rise_detect.sv
// Rising-edge detector.
// Ports:
//   clk   : clock, rising edge.
//   reset : synchronous active-high reset; clears the delayed copy.
//   d     : input to watch.
//   pulse : high in the same cycle d rises (combinational on d).
module rise_detect #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] pulse
);

   logic [DATA_WIDTH-1:0] d_q;

   // Delayed copy of the input, one cycle behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_q <= '0;
      end else begin
         d_q <= d;
      end
   end

   // The pulse uses the live input so the edge acts in the cycle it occurs.
   assign pulse = d & ~d_q;

endmodule

// File: rtl/read_queue.sv
// read_queue: narrow-to-wide deserializer.
// Gathers MAX = OUT_WIDTH/IN_WIDTH accepted IN_WIDTH-bit beats and presents
// them as one OUT_WIDTH-bit word, first beat in the least significant lane.
// Ports:
//   clk          : clock, rising edge.
//   reset        : synchronous active-high reset.
//   din          : narrow input beat.
//   vld_in       : din valid.
//   rdy_upward   : ready to upstream (combinational).
//   dout         : assembled wide word (registered).
//   vld_out      : dout valid (registered).
//   rdy_downward : downstream ready.
//   ap_start     : kernel start; a rising edge discards any partial or held word.
module read_queue
   import read_queue_pkg::*;
#(
   parameter int IN_WIDTH  = IN_WIDTH_DEF,
   parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  din,
   input  logic                 vld_in,
   output logic                 rdy_upward,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 vld_out,
   input  logic                 rdy_downward,
   input  logic                 ap_start
);

   localparam int MAX   = beats_per_word(OUT_WIDTH, IN_WIDTH);
   localparam int CNT_W = $clog2(MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                         state_r;
   logic [CNT_W-1:0]               cnt_r;
   // Only the upper OUT_WIDTH-IN_WIDTH bits of the shift register are kept:
   // the lowest lane would be shifted out by the very beat that completes a
   // word, so it is never observable.
   logic [OUT_WIDTH-IN_WIDTH-1:0]  sh_r;
   logic [OUT_WIDTH-1:0]           dout_r;
   logic                           vld_out_r;

   logic                           start_pulse_s;
   logic                           rdy_s;
   logic                           beat_acc_s;
   logic                           word_acc_s;
   logic [OUT_WIDTH-1:0]           shifted_s;

   rise_detect #(
      .DATA_WIDTH (1)
   ) u_start_edge (
      .clk   (clk),
      .reset (reset),
      .d     (ap_start),
      .pulse (start_pulse_s)
   );

   assign shifted_s  = {din, sh_r};
   assign beat_acc_s = vld_in & rdy_s;
   assign word_acc_s = vld_out_r & rdy_downward;

   // Upstream ready: open while collecting, follows downstream while holding.
   always_comb begin
      rdy_s = 1'b0;
      if (reset || start_pulse_s) begin
         rdy_s = 1'b0;
      end else begin
         case (state_r)
            COLLECT: rdy_s = 1'b1;
            HOLD:    rdy_s = rdy_downward;
            default: rdy_s = 1'b0;
         endcase
      end
   end

   // Packer state, beat counter, shift register and registered output word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= COLLECT;
         cnt_r     <= '0;
         sh_r      <= '0;
         dout_r    <= '0;
         vld_out_r <= 1'b0;
      end else if (start_pulse_s) begin
         state_r   <= COLLECT;
         cnt_r     <= '0;
         vld_out_r <= 1'b0;
      end else begin
         case (state_r)
            COLLECT: begin
               if (beat_acc_s) begin
                  sh_r <= shifted_s[OUT_WIDTH-1:IN_WIDTH];
                  if (cnt_r == CNT_LAST) begin
                     dout_r    <= shifted_s;
                     vld_out_r <= 1'b1;
                     cnt_r     <= '0;
                     state_r   <= HOLD;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            HOLD: begin
               if (word_acc_s) begin
                  vld_out_r <= 1'b0;
                  state_r   <= COLLECT;
                  // A beat taken alongside the word starts the next word.
                  if (beat_acc_s) begin
                     sh_r  <= shifted_s[OUT_WIDTH-1:IN_WIDTH];
                     cnt_r <= CNT_ONE;
                  end else begin
                     cnt_r <= '0;
                  end
               end
            end
            default: begin
               state_r   <= COLLECT;
               cnt_r     <= '0;
               vld_out_r <= 1'b0;
            end
         endcase
      end
   end

   assign rdy_upward = rdy_s;
   assign dout       = dout_r;
   assign vld_out    = vld_out_r;

endmodule

// File: tb/tb_read_queue.sv
// Self-checking bench for read_queue (IN=32, OUT=512).
// A reference model at the posedge tracks accepted beats as a list and pushes
// each completed 16-beat word into a scoreboard queue; a monitor at the
// negedge compares handshakes and the presented word against it.
module tb_read_queue;

   localparam int IN_W  = 32;
   localparam int OUT_W = 512;
   localparam int NB    = OUT_W / IN_W;

   logic             clk = 1'b0;
   logic             reset;
   logic [IN_W-1:0]  din;
   logic             vld_in;
   logic             rdy_upward;
   logic [OUT_W-1:0] dout;
   logic             vld_out;
   logic             rdy_downward;
   logic             ap_start;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [IN_W-1:0]  cur[$];
   logic [OUT_W-1:0] exp_q[$];
   bit               holding = 1'b0;
   bit               ap_prev = 1'b0;
   bit               acc_flag = 1'b0;
   logic [OUT_W-1:0] last_word = '0;
   int               words_seen = 0;

   read_queue dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .vld_in       (vld_in),
      .rdy_upward   (rdy_upward),
      .dout         (dout),
      .vld_out      (vld_out),
      .rdy_downward (rdy_downward),
      .ap_start     (ap_start)
   );

   always #5 clk = ~clk;

   // Reference model: decides acceptance from the rules, not from DUT outputs.
   initial begin
      forever begin
         @(posedge clk);
         acc_flag = 1'b0;
         if (reset) begin
            cur.delete();
            exp_q.delete();
            holding = 1'b0;
            ap_prev = 1'b0;
         end else begin
            bit pulse;
            pulse   = ap_start && !ap_prev;
            ap_prev = ap_start;
            if (pulse) begin
               cur.delete();
               if (holding) void'(exp_q.pop_front());
               holding = 1'b0;
            end else begin
               bit rdy;
               rdy = !holding || rdy_downward;
               if (holding && rdy_downward) begin
                  void'(exp_q.pop_front());
                  holding = 1'b0;
               end
               if (vld_in && rdy) begin
                  acc_flag = 1'b1;
                  cur.push_back(din);
                  if (cur.size() == NB) begin
                     logic [OUT_W-1:0] w;
                     for (int k = 0; k < NB; k++) w[k*IN_W +: IN_W] = cur[k];
                     exp_q.push_back(w);
                     cur.delete();
                     holding = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Monitor: compares handshakes and held word against the model each cycle.
   initial begin
      forever begin
         bit exp_rdy;
         @(negedge clk);
         exp_rdy = !reset && !(ap_start && !ap_prev) && (!holding || rdy_downward);
         checks++;
         if (rdy_upward !== exp_rdy) begin
            failures++;
            $display("FAIL rdy_upward t=%0t got=%b exp=%b", $time, rdy_upward, exp_rdy);
         end
         checks++;
         if (vld_out !== holding) begin
            failures++;
            $display("FAIL vld_out t=%0t got=%b exp=%b", $time, vld_out, holding);
         end
         if (vld_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL dout_unexpected t=%0t got=%h exp=none", $time, dout);
            end else if (dout !== exp_q[0]) begin
               failures++;
               $display("FAIL dout t=%0t got=%h exp=%h", $time, dout, exp_q[0]);
            end
            if (rdy_downward) begin
               last_word = dout;
               words_seen++;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Sends n consecutive beats starting at first; a refused beat is held.
   task automatic send_beats(input int n, input logic [IN_W-1:0] first, input bit rd);
      logic [IN_W-1:0] val;
      int sent;
      int guard;
      val = first;
      sent = 0;
      guard = 0;
      while (sent < n && guard < 400) begin
         vld_in = 1'b1;
         din = val;
         rdy_downward = rd;
         cyc();
         guard++;
         if (acc_flag) begin
            sent++;
            val = val + 32'd1;
         end
      end
      vld_in = 1'b0;
      checks++;
      if (sent != n) begin
         failures++;
         $display("FAIL send_beats sent=%0d exp=%0d", sent, n);
      end
   endtask

   task automatic check_val(input string name, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   initial begin
      int w0;
      reset = 1'b1;
      din = '0;
      vld_in = 1'b0;
      rdy_downward = 1'b0;
      ap_start = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      check_val("reset_vld_out", {31'd0, vld_out}, 32'd0);
      checks++;
      if (dout !== '0) begin
         failures++;
         $display("FAIL reset_dout got=%h exp=0", dout);
      end

      // Three back-to-back words 1..48, no backpressure.
      w0 = words_seen;
      send_beats(48, 32'd1, 1'b1);
      cyc();
      cyc();
      check_val("b2b_words", 32'(words_seen - w0), 32'd3);
      check_val("b2b_first_lane", last_word[31:0], 32'd33);
      check_val("b2b_last_lane", last_word[511:480], 32'd48);

      // Word held for 5 cycles under backpressure while upstream keeps offering.
      send_beats(16, 32'h100, 1'b0);
      vld_in = 1'b1;
      din = 32'h200;
      rdy_downward = 1'b0;
      repeat (5) cyc();
      check_val("hold_not_taken", {31'd0, acc_flag}, 32'd0);
      w0 = words_seen;
      rdy_downward = 1'b1;
      cyc();
      check_val("hold_release_beat", {31'd0, acc_flag}, 32'd1);
      vld_in = 1'b0;
      cyc();
      check_val("hold_once", 32'(words_seen - w0), 32'd1);
      check_val("hold_word_lane0", last_word[31:0], 32'h100);

      // Randomised gaps and backpressure; upstream holds a refused beat.
      for (int i = 0; i < 600; i++) begin
         if (!vld_in || acc_flag) begin
            vld_in = ($urandom_range(0, 9) < 7);
            din = $urandom;
         end
         rdy_downward = $urandom_range(0, 1);
         cyc();
      end
      vld_in = 1'b0;
      rdy_downward = 1'b1;
      repeat (3) cyc();

      // Partial of 7 beats, then ap_start rises and discards it.
      send_beats(7, 32'h50, 1'b1);
      ap_start = 1'b1;
      vld_in = 1'b1;
      din = 32'hA0;
      cyc();
      check_val("flush_refused", {31'd0, acc_flag}, 32'd0);
      send_beats(16, 32'hA0, 1'b1);
      cyc();
      check_val("flush_lane0", last_word[31:0], 32'hA0);
      check_val("flush_lane15", last_word[511:480], 32'hAF);
      // ap_start still high: no further flush.
      send_beats(16, 32'hC0, 1'b1);
      cyc();
      check_val("nof_lane0", last_word[31:0], 32'hC0);
      ap_start = 1'b0;

      // Reset while a word is held.
      send_beats(16, 32'h300, 1'b0);
      check_val("pre_reset_vld", {31'd0, vld_out}, 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_val("post_reset_vld", {31'd0, vld_out}, 32'd0);
      checks++;
      if (dout !== '0) begin
         failures++;
         $display("FAIL post_reset_dout got=%h exp=0", dout);
      end
      send_beats(16, 32'h400, 1'b1);
      cyc();
      check_val("post_reset_lane0", last_word[31:0], 32'h400);
      check_val("post_reset_lane15", last_word[511:480], 32'h40F);
      repeat (2) cyc();
      check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/read_queue.md
Name: read_queue

Overview:
- Narrow-to-wide deserializer.
- Collects MAX = OUT_WIDTH/IN_WIDTH consecutive IN_WIDTH-bit beats from a valid/ready stream and presents them as one OUT_WIDTH-bit word on a valid/ready output.
- Counterpart of the wide-to-narrow serializer on the leaf-to-DMA path; packs 32-bit operator output into 512-bit words for the memory side.
- Full throughput: one wide word per MAX cycles under no backpressure.

Parameters:
- IN_WIDTH, 32, narrow input beat width.
- OUT_WIDTH, 512, wide output word width; must be an integer multiple of IN_WIDTH.
- MAX (localparam), OUT_WIDTH/IN_WIDTH, beats per word; must be >= 2.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  IN_WIDTH  narrow input beat.
- vld_in  input  1  din valid.
- rdy_upward  output  1  ready to upstream (combinational).
- dout  output  OUT_WIDTH  assembled wide word (registered).
- vld_out  output  1  dout valid (registered).
- rdy_downward  input  1  downstream ready.
- ap_start  input  1  kernel start; its rising edge soft-resets the packer.

Behaviour:
- Reset (synchronous): state=COLLECT, cnt=0, dout=0, vld_out=0, ap_start_d=0. While reset is high, rdy_upward=0.
- Beat accept: vld_in && rdy_upward.
- Word accept: vld_out && rdy_downward.
- Beat order: first accepted beat lands in dout[IN_WIDTH-1:0]; beat k lands in dout[(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Assembly: shift register sh (OUT_WIDTH bits). Each accepted beat does sh <= {din, sh[OUT_WIDTH-1:IN_WIDTH]}.
- cnt: $clog2(MAX) bits; counts accepted beats in the current word.
- COLLECT state:
  - rdy_upward=1; vld_out=0.
  - On beat accept with cnt<MAX-1: shift, cnt++.
  - On beat accept with cnt==MAX-1: dout <= {din, sh[OUT_WIDTH-1:IN_WIDTH]}, vld_out<=1, cnt<=0, state<=HOLD.
- HOLD state:
  - vld_out=1; dout stable until word accept; rdy_upward=rdy_downward.
  - Word accept without beat accept: vld_out<=0, state<=COLLECT.
  - Word accept with simultaneous beat accept: that beat is beat 0 of the next word (sh shifted, cnt<=1), state<=COLLECT. No bubble.
  - vld_in while rdy_downward=0: not accepted; upstream must hold.
- Latency: vld_out rises in the cycle after the MAX-th beat is accepted.
- Soft reset: start_pulse = ap_start & ~ap_start_d, evaluated in the same cycle.
  - That cycle: rdy_upward=0.
  - Next cycle: state=COLLECT, cnt=0, vld_out=0. Any partial word or undelivered held word is discarded.
  - sh need not be cleared; stale bits are overwritten by the next MAX beats.
- Priority: reset > start_pulse > normal handshakes.
- cnt never exceeds MAX-1; there is no wrap beyond the word boundary.
- vld_out never deasserts without a word accept, except on reset or start_pulse.

Decomposition:
- Shared package: IN_WIDTH/OUT_WIDTH defaults, COLLECT/HOLD state encodings (1 bit).
- Sub-module rise_detect (data_width=1) for the ap_start edge. Its output must be combinational on the current input so start_pulse takes effect in the same cycle; otherwise the edge detect is inlined.
- No other sub-modules.

Test Plan:
- Continuous vld_in, rdy_downward=1, din=1..16 (IN=32, OUT=512) -> vld_out high for 1 cycle, one cycle after beat 16; dout[31:0]=1, dout[511:480]=16; next word starts with no bubble.
- Back-to-back 3 words (din=0..47), rdy_downward=1 -> 3 words in 48+1 cycles; the beat in each HOLD cycle becomes beat 0 of the next word.
- Word held with rdy_downward=0 for 5 cycles -> dout/vld_out stable, rdy_upward=0 throughout; release -> word accepted once, no beat lost.
- Random vld_in gaps (~30%) and random rdy_downward -> scoreboard: every output word equals 16 consecutive accepted beats, LSB-first, no loss or duplication.
- ap_start rising after 7 beats -> partial discarded; next 16 beats (0xA0..0xAF) form a word with dout[31:0]=0xA0; ap_start held high -> no further flushes.
- reset asserted while vld_out=1 -> next cycle vld_out=0, dout=0, cnt=0; the first 16 beats after reset form a complete word.
